// File: rtl/dual_rail_output_buffer.sv
// dual_rail_output_buffer: dual-rail completion/spacer detect with 4-phase ack, decoded into a valid/ready FIFO (optional level_o under DR_OUT_LEVEL_EN); ports ck, arst, data_1_i, data_0_i, ack_o, data_o, valid_o, ready_i, err_o[, level_o]
module dual_rail_output_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit SIGN_ZERO = 1
) (
  input  logic             ck,
  input  logic             arst,
  input  logic [WIDTH-1:0] data_1_i,
  input  logic [WIDTH-1:0] data_0_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
`ifdef DR_OUT_LEVEL_EN
  output logic [$clog2(DEPTH+1)-1:0] level_o,
`endif
  output logic             err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] CHK = SIGN_ZERO ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  typedef enum logic {EXPECT_NULL, EXPECT_DATA} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rnext;
  logic [CW-1:0] count;
  logic complete, spacer, illegal, pop, push;
  logic [WIDTH-1:0] word;
  assign complete = &((data_1_i ^ data_0_i) | ~CHK);
  assign spacer = ~|((data_1_i | data_0_i) & CHK);
  assign illegal = |(data_1_i & data_0_i & CHK);
  assign word = data_1_i & CHK;
  assign valid_o = count != '0;
  assign pop = valid_o && ready_i;
  assign push = state == EXPECT_DATA && complete && (count != CW'(DEPTH) || pop);
  assign rnext = rptr + 1'b1;
`ifdef DR_OUT_LEVEL_EN
  assign level_o = count;
`endif
  always_ff @(posedge ck)
    if (push) mem[wptr] <= word;
  always_ff @(posedge ck) begin
    if (arst) begin
      state <= EXPECT_NULL;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      data_o <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (illegal) err_o <= 1'b1;
      if (state == EXPECT_NULL && spacer) begin
        ack_o <= 1'b0;
        state <= EXPECT_DATA;
      end else if (state == EXPECT_DATA && (illegal || push)) begin
        ack_o <= 1'b1;
        state <= EXPECT_NULL;
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rnext;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // head register tracks the entry that will be at rptr after this edge
      if (pop && count > CW'(1)) data_o <= mem[rnext];
      else if (push && (count == '0 || (pop && count == CW'(1)))) data_o <= word;
    end
  end
endmodule

// File: tb/tb_dual_rail_output_buffer.sv
// tb_dual_rail_output_buffer: directed plus random stimulus against a queue-based reference model
module tb_dual_rail_output_buffer;
  logic ck = 0, arst = 1, ready_i = 0;
  logic [31:0] data_1_i = 0, data_0_i = 0;
  logic ack_o, valid_o, err_o;
  logic [31:0] data_o;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic m_ack = 0, m_err = 0, m_exp_data = 0;

  dual_rail_output_buffer dut (
    .ck(ck), .arst(arst), .data_1_i(data_1_i), .data_0_i(data_0_i),
    .ack_o(ack_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic r, input logic rs);
    int nv, nn, ni;
    bit comp, spc, ill, pop, room;
    if (rs) begin
      q.delete(); m_ack = 0; m_err = 0; m_exp_data = 0;
      return;
    end
    nv = 0; nn = 0; ni = 0;
    for (int i = 0; i < 31; i++) begin
      if (a[i] != b[i]) nv++;
      else if (!a[i]) nn++;
      else ni++;
    end
    comp = nv == 31; spc = nn == 31; ill = ni > 0;
    pop = q.size() > 0 && r;
    room = q.size() < 4 || pop;
    if (pop) void'(q.pop_front());
    if (ill) m_err = 1;
    if (!m_exp_data) begin
      if (spc) begin m_ack = 0; m_exp_data = 1; end
    end else if (ill) begin
      m_ack = 1; m_exp_data = 0;
    end else if (comp && room) begin
      q.push_back({1'b0, a[30:0]}); m_ack = 1; m_exp_data = 0;
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic r, input logic rs);
    data_1_i = a; data_0_i = b; ready_i = r; arst = rs;
    @(posedge ck);
    model(a, b, r, rs);
    #1;
    chk("ack", ack_o, m_ack);
    chk("valid", valid_o, q.size() != 0);
    chk("err", err_o, m_err);
    if (q.size() != 0) chk("data", data_o, q[0]);
  endtask

  task automatic tok(input logic [31:0] w, input logic r);
    step(w, ~w, r, 0);
  endtask

  task automatic spc(input logic r);
    step(0, 0, r, 0);
  endtask

  initial begin
    logic [31:0] w, m;
    int k;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_data", data_o, 0);
    chk("rst_ack", ack_o, 0);
    spc(0);
    tok(32'h3FB504F3, 0);
    chk("sqrt2_ack", ack_o, 1);
    chk("sqrt2_data", data_o, 32'h3FB504F3);
    spc(1);
    chk("spacer_ack", ack_o, 0);
    step(32'hC0000000, 32'h3FFFFFFF, 0, 0);
    chk("sign_force", data_o, 32'h40000000);
    spc(1);
    step(32'h40000000, 32'h3FFFFFFF, 0, 0);
    chk("sign_null_ok", ack_o, 1);
    spc(1);
    for (int i = 1; i <= 4; i++) begin
      tok(i, 0);
      spc(0);
    end
    for (int i = 0; i < 3; i++) tok(5, 0);
    chk("bp_ack", ack_o, 0);
    tok(5, 1);
    chk("bp_push_ack", ack_o, 1);
    for (int i = 2; i <= 5; i++) begin
      chk("drain", data_o, i);
      spc(1);
    end
    chk("drained", valid_o, 0);
    w = 32'h1234ABCD;
    for (int i = 0; i < 3; i++) step(w & 32'h0000FFFF, ~w & 32'h0000FFFF, 0, 0);
    chk("partial_ack", ack_o, 0);
    tok(w, 0);
    chk("partial_done", data_o, 32'h1234ABCD);
    spc(0);
    step(32'h00000080, 32'hFFFFFFFF, 0, 0);
    chk("illegal_err", err_o, 1);
    spc(0);
    tok(32'h00000042, 0);
    chk("post_illegal_ack", ack_o, 1);
    chk("err_sticky", err_o, 1);
    step(0, 0, 0, 1);
    chk("rst2_valid", valid_o, 0);
    chk("rst2_err", err_o, 0);
    chk("rst2_data", data_o, 0);
    for (int i = 0; i < 3; i++) tok(32'h00000077, 0);
    chk("no_capture", valid_o, 0);
    spc(0);
    tok(32'h00000077, 0);
    chk("after_rst_tok", data_o, 32'h00000077);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 49);
      w = $urandom;
      m = $urandom;
      if (k < 25) tok(w, $urandom_range(0, 2) == 0);
      else if (k < 40) spc($urandom_range(0, 1) == 1);
      else if (k < 49) step(w & m, ~w & m, $urandom_range(0, 1) == 1, 0);
      else step(w, w, $urandom_range(0, 1) == 1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
